multicycle_control: RTL and testbench

- Multicycle sequencer for the RV32 subset datapath: PC register, instruction memory, register bank, ALU, data memory and the 3:1 write-back mux.
- Replaces the single-cycle combinational control unit.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Handshakes with instruction and data memories that may stall.
- Raises a sticky trap on illegal encodings and counts retired instructions.

---
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RV32-subset sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, sticky illegal-op trap, retire counter.
// Zero-wait latency LUI 3 / ALU 4 / store 4 / load 5 cycles; FETCH and MEMORY hold until imem_ready/dmem_ready.
module multicycle_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_load,
  output logic [31:0]      pc_load_val,
  output logic             reg_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_sel,
  output logic             imm_src,
  output logic             busy,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_LUI} kind_t;

  state_t     state;
  kind_t      kind;

  kind_t      dec_kind;
  logic       dec_legal;
  logic       dec_alu_src;
  logic [1:0] dec_alu_op;
  logic       dec_imm_src;
  logic [1:0] dec_result_sel;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       instr_unused;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign instr_unused = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec_legal      = 1'b0;
    dec_kind       = K_ALU;
    dec_alu_src    = 1'b0;
    dec_alu_op     = 2'b00;
    dec_imm_src    = 1'b0;
    dec_result_sel = 2'b00;
    case (opcode)
      7'b0110011: begin
        if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
          dec_legal  = 1'b1;
          dec_alu_op = funct7[5] ? 2'b01 : 2'b00;
        end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
          dec_legal  = 1'b1;
          dec_alu_op = 2'b10;
        end else if (funct3 == 3'b110 && funct7 == 7'b0000000) begin
          dec_legal  = 1'b1;
          dec_alu_op = 2'b11;
        end
      end
      7'b0010011: begin
        dec_alu_src = 1'b1;
        dec_imm_src = 1'b1;
        case (funct3)
          3'b000:  begin dec_legal = 1'b1; dec_alu_op = 2'b00; end
          3'b111:  begin dec_legal = 1'b1; dec_alu_op = 2'b10; end
          3'b110:  begin dec_legal = 1'b1; dec_alu_op = 2'b11; end
          default: dec_legal = 1'b0;
        endcase
      end
      7'b0000011: begin
        dec_legal      = (funct3 == 3'b010);
        dec_kind       = K_LOAD;
        dec_alu_src    = 1'b1;
        dec_imm_src    = 1'b1;
        dec_result_sel = 2'b01;
      end
      7'b0100011: begin
        dec_legal   = (funct3 == 3'b010);
        dec_kind    = K_STORE;
        dec_alu_src = 1'b1;
      end
      7'b0110111: begin
        dec_legal      = 1'b1;
        dec_kind       = K_LUI;
        dec_result_sel = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Selects are captured on leaving DECODE so they hold steady until the instruction retires.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      kind       <= K_ALU;
      trap       <= 1'b0;
      instret    <= '0;
      alu_src    <= 1'b0;
      alu_op     <= 2'b00;
      imm_src    <= 1'b0;
      result_sel <= 2'b00;
    end else begin
      case (state)
        S_IDLE:   if (run) state <= S_FETCH;
        S_FETCH:  if (imem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (!dec_legal) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            kind       <= dec_kind;
            alu_src    <= dec_alu_src;
            alu_op     <= dec_alu_op;
            imm_src    <= dec_imm_src;
            result_sel <= dec_result_sel;
            state      <= (dec_kind == K_LUI) ? S_WB : S_EXEC;
          end
        end
        S_EXEC:   state <= (kind == K_LOAD || kind == K_STORE) ? S_MEM : S_WB;
        S_MEM: begin
          if (dmem_ready) begin
            if (kind == K_STORE) begin
              instret <= instret + CNT_W'(1);
              state   <= run ? S_FETCH : S_IDLE;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          instret <= instret + CNT_W'(1);
          state   <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP: begin
          if (trap_clr) begin
            trap  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign ir_we       = (state == S_FETCH) && imem_ready;
  assign dmem_req    = (state == S_MEM);
  assign dmem_we     = (state == S_MEM) && (kind == K_STORE);
  assign reg_we      = (state == S_WB);
  assign pc_we       = (state == S_WB) || ((state == S_MEM) && (kind == K_STORE) && dmem_ready);
  assign pc_load     = (state == S_TRAP) && trap_clr;
  assign pc_load_val = RESET_PC;
  assign busy        = (state != S_IDLE) && (state != S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectations built from the instruction class and wait counts.
module tb_multicycle_control;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          CW  = 4;

  localparam logic [2:0] C_ALU = 3'd0, C_LD = 3'd1, C_ST = 3'd2, C_LUI = 3'd3, C_ILL = 3'd4;

  logic CLK, RST, run, imem_ready, dmem_ready, trap_clr;
  logic [31:0] instr;
  logic imem_req, ir_we, pc_we, pc_load, reg_we, dmem_req, dmem_we;
  logic alu_src, imm_src, busy, trap;
  logic [1:0] alu_op, result_sel;
  logic [31:0] pc_load_val;
  logic [CW-1:0] instret;

  multicycle_control #(.RESET_PC(RPC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .run(run), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .trap_clr(trap_clr), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_load(pc_load), .pc_load_val(pc_load_val), .reg_we(reg_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_src(alu_src), .alu_op(alu_op),
    .result_sel(result_sel), .imm_src(imm_src), .busy(busy), .trap(trap), .instret(instret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic imem_req, ir_we, pc_we, pc_load, reg_we, dmem_req, dmem_we, busy, trap;
  } strb_t;

  // sel layout: {alu_src, alu_op[1:0], imm_src, result_sel[1:0]}
  typedef struct packed {
    logic [2:0] cls;
    logic [5:0] sel;
    logic [5:0] mask;
  } dec_t;

  int total = 0;
  int bad   = 0;

  strb_t         e_s;
  strb_t         a_s;
  logic [5:0]    e_sel, e_mask, a_sel;
  logic [CW-1:0] m_instret;
  logic          chk_en = 1'b0;
  int            lat_cnt = 0;
  int            last_lat = 0;

  function automatic strb_t mk(input logic ireq, irw, pcw, pcl, rw, dreq, dwe, bsy, trp);
    mk = {ireq, irw, pcw, pcl, rw, dreq, dwe, bsy, trp};
  endfunction

  function automatic dec_t classify(input logic [31:0] w);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    d.cls = C_ILL; d.sel = '0; d.mask = '0;
    case (w[6:0])
      7'b0110011: begin
        d.mask = 6'b111011;
        if (f3 == 3'd0 && f7 == 7'h00)      begin d.cls = C_ALU; d.sel = 6'b000000; end
        else if (f3 == 3'd0 && f7 == 7'h20) begin d.cls = C_ALU; d.sel = 6'b001000; end
        else if (f3 == 3'd7 && f7 == 7'h00) begin d.cls = C_ALU; d.sel = 6'b010000; end
        else if (f3 == 3'd6 && f7 == 7'h00) begin d.cls = C_ALU; d.sel = 6'b011000; end
      end
      7'b0010011: begin
        d.mask = 6'b111111;
        if (f3 == 3'd0)      begin d.cls = C_ALU; d.sel = 6'b100100; end
        else if (f3 == 3'd7) begin d.cls = C_ALU; d.sel = 6'b110100; end
        else if (f3 == 3'd6) begin d.cls = C_ALU; d.sel = 6'b111100; end
      end
      7'b0000011: if (f3 == 3'd2) begin d.cls = C_LD; d.sel = 6'b100101; d.mask = 6'b111111; end
      7'b0100011: if (f3 == 3'd2) begin d.cls = C_ST; d.sel = 6'b100000; d.mask = 6'b111100; end
      7'b0110111: begin d.cls = C_LUI; d.sel = 6'b000010; d.mask = 6'b000011; end
      default: d.cls = C_ILL;
    endcase
    return d;
  endfunction

  always @(negedge CLK) begin
    #1;
    if (chk_en) begin
      a_s   = {imem_req, ir_we, pc_we, pc_load, reg_we, dmem_req, dmem_we, busy, trap};
      a_sel = {alu_src, alu_op, imm_src, result_sel};
      total++;
      if (a_s !== e_s) begin
        bad++;
        $display("FAIL strobes @%0t got=%b want=%b", $time, a_s, e_s);
      end
      total++;
      if (instret !== m_instret) begin
        bad++;
        $display("FAIL instret @%0t got=%0d want=%0d", $time, instret, m_instret);
      end
      if (e_mask != 6'b0) begin
        total++;
        if ((a_sel & e_mask) !== (e_sel & e_mask)) begin
          bad++;
          $display("FAIL selects @%0t got=%b want=%b mask=%b", $time, a_sel, e_sel, e_mask);
        end
      end
    end
    if (pc_we === 1'b1) begin
      last_lat = lat_cnt + 1;
      lat_cnt  = 0;
    end else if (busy === 1'b1) lat_cnt++;
    else lat_cnt = 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic ir, input logic dr, input logic tc,
                      input strb_t s, input logic [5:0] sel, input logic [5:0] mask);
    @(negedge CLK);
    run = r; imem_ready = ir; dmem_ready = dr; trap_clr = tc;
    e_s = s; e_sel = sel; e_mask = mask; chk_en = 1'b1;
    #2;
  endtask

  task automatic do_instr(input logic [31:0] w, input logic from_idle, input int iw,
                          input int dw, input logic run_end, input logic abort);
    dec_t d;
    logic st, ld;
    d  = classify(w);
    st = (d.cls == C_ST);
    ld = (d.cls == C_LD);
    instr = w;
    if (from_idle) step(1, 0, 0, 1, mk(0,0,0,0,0,0,0,0,0), 6'b0, 6'b0);
    for (int i = 0; i < iw; i++) step(0, 0, 0, 0, mk(1,0,0,0,0,0,0,1,0), 6'b0, 6'b0);
    step(run_end, 1, 0, 0, mk(1,1,0,0,0,0,0,1,0), 6'b0, 6'b0);
    step(run_end, 0, 0, 0, mk(0,0,0,0,0,0,0,1,0), 6'b0, 6'b0);
    if (d.cls == C_ILL) begin
      step(1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1), 6'b0, 6'b0);
      step(1, 0, 0, 0, mk(0,0,0,0,0,0,0,0,1), 6'b0, 6'b0);
      step(1, 0, 0, 1, mk(0,0,0,1,0,0,0,0,1), 6'b0, 6'b0);
      return;
    end
    if (d.cls != C_LUI) step(run_end, 0, 0, 0, mk(0,0,0,0,0,0,0,1,0), d.sel, d.mask);
    if (st || ld) begin
      for (int i = 0; i < dw; i++) begin
        step(run_end, 0, 0, 0, mk(0,0,0,0,0,1,st,1,0), d.sel, d.mask);
        if (abort) begin
          #1;
          RST = 1'b0;
          #1;
          chk("abort_strobes", {imem_req, ir_we, pc_we, pc_load, reg_we, dmem_req, dmem_we}, 0);
          chk("abort_busy", busy, 0);
          chk("abort_instret", instret, 0);
          chk_en = 1'b0;
          run = 1'b0;
          m_instret = '0;
          @(negedge CLK);
          RST = 1'b1;
          return;
        end
      end
      step(run_end, 0, 1, 0, mk(0,0,st,0,0,1,st,1,0), d.sel, d.mask);
      if (st) begin
        m_instret = m_instret + 1'b1;
        return;
      end
    end
    step(run_end, 0, 0, 0, mk(0,0,1,0,1,0,0,1,0), d.sel, d.mask);
    m_instret = m_instret + 1'b1;
  endtask

  task automatic after_edge;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; trap_clr = 1'b0;
    instr = '0; m_instret = '0;
    #1;
    chk("rst_strobes", {imem_req, ir_we, pc_we, pc_load, reg_we, dmem_req, dmem_we}, 0);
    chk("rst_busy_trap", {busy, trap}, 0);
    chk("rst_instret", instret, 0);
    chk("rst_selects", {alu_src, alu_op, imm_src, result_sel}, 0);
    chk("pc_load_val", pc_load_val, 32'h0000_0100);
    @(negedge CLK);
    RST = 1'b1;
    step(0, 0, 0, 0, mk(0,0,0,0,0,0,0,0,0), 6'b0, 6'b0);

    do_instr(32'h00500093, 1, 0, 0, 1, 0); after_edge;
    chk("addi_lat", last_lat, 4);
    chk("addi_instret", instret, 1);
    do_instr(32'h40208133, 0, 0, 0, 1, 0); after_edge;
    chk("sub_lat", last_lat, 4);
    chk("sub_instret", instret, 2);
    do_instr(32'h0000A183, 0, 0, 3, 1, 0); after_edge;
    chk("lw_lat", last_lat, 8);
    do_instr(32'h0030A223, 0, 0, 0, 0, 0); after_edge;
    chk("sw_lat", last_lat, 4);
    chk("sw_idle", busy, 0);
    do_instr(32'h123450B7, 1, 0, 0, 1, 0); after_edge;
    chk("lui_lat", last_lat, 3);
    chk("lui_instret", instret, 5);
    do_instr(32'hFFFFFFFF, 0, 0, 0, 1, 0); after_edge;
    chk("trap_instret", instret, 5);
    chk("trap_cleared", {trap, busy}, 0);
    do_instr(32'h0020C133, 1, 0, 0, 1, 0); after_edge;
    chk("xor_trap_instret", instret, 5);
    do_instr(32'h0020F1B3, 1, 0, 0, 1, 0);
    do_instr(32'h0020E1B3, 0, 0, 0, 1, 0);
    do_instr(32'h00F0F093, 0, 2, 0, 1, 0); after_edge;
    chk("andi_wait_lat", last_lat, 6);
    do_instr(32'h00F0E093, 0, 0, 0, 1, 0);
    do_instr(32'h0030A223, 0, 1, 2, 1, 0); after_edge;
    chk("sw_wait_lat", last_lat, 7);
    for (int k = 0; k < 8; k++) do_instr(32'h00500093, 0, 0, 0, 1, 0);
    after_edge;
    chk("instret_wrap", instret, 2);
    do_instr(32'h0000A183, 0, 0, 5, 1, 1);
    do_instr(32'h00500093, 1, 0, 0, 0, 0); after_edge;
    chk("post_abort_instret", instret, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
